// File: rtl/bulls_cows_arena.sv
// rtl/bulls_cows_arena.sv - parametrised N-player Bulls & Cows game controller
`default_nettype none

module bulls_cows_arena #(
    parameter int N_DIGITS   = 4,
    parameter int DIGIT_W    = 4,
    parameter int DIGIT_MAX  = 9,
    parameter int N_PLAYERS  = 2,
    parameter int MAX_ROUNDS = 8,
    localparam int CODE_W    = N_DIGITS * DIGIT_W,
    localparam int PW        = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1,
    localparam int CW        = $clog2(N_DIGITS + 1),
    localparam int RW        = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CODE_W-1:0]    sw,
    input  logic                 enter,
    output logic [2:0]           state_o,
    output logic [PW-1:0]        player_o,
    output logic [CW-1:0]        bulls_o,
    output logic [CW-1:0]        cows_o,
    output logic [RW-1:0]        round_o,
    output logic [N_PLAYERS-1:0] win_o,
    output logic                 draw_o,
    output logic                 reject_o,
    output logic                 busy_o
);

    localparam int IW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0]      LAST_P = PW'(N_PLAYERS - 1);
    localparam logic [IW-1:0]      LAST_D = IW'(N_DIGITS - 1);
    localparam logic [DIGIT_W-1:0] D_MAX  = DIGIT_W'(DIGIT_MAX);
    localparam logic [CW-1:0]      ALL_BULLS = CW'(N_DIGITS);
    localparam logic [RW-1:0]      ROUND_LIMIT = RW'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        S_SETUP  = 3'd0,
        S_GUESS  = 3'd1,
        S_CALC   = 3'd2,
        S_RESULT = 3'd3,
        S_WIN    = 3'd4,
        S_DRAW   = 3'd5
    } state_t;

    state_t state, state_n;

    logic [CODE_W-1:0] secret [N_PLAYERS];
    logic [CODE_W-1:0] guess;
    logic [CODE_W-1:0] target;
    logic [PW-1:0]     player, next_player;
    logic [RW-1:0]     round, round_n;
    logic [CW-1:0]     bulls, cows, bulls_n, cows_n;
    logic [IW-1:0]     idx_i, idx_j;
    logic              enter_q, reject;
    logic              ent, code_ok, hit, last_pair;
    logic [DIGIT_W-1:0] g_digit, t_digit;

    // A code is legal when every digit is in range and no digit repeats
    function automatic logic code_valid(input logic [CODE_W-1:0] code);
        logic ok;
        ok = 1'b1;
        for (int a = 0; a < N_DIGITS; a++) begin
            if (code[a*DIGIT_W +: DIGIT_W] > D_MAX) ok = 1'b0;
            for (int b = a + 1; b < N_DIGITS; b++) begin
                if (code[a*DIGIT_W +: DIGIT_W] == code[b*DIGIT_W +: DIGIT_W]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    assign ent         = enter & ~enter_q;
    assign code_ok     = code_valid(sw);
    assign next_player = (player == LAST_P) ? '0 : player + PW'(1);
    assign round_n     = (round == ROUND_LIMIT) ? round : round + RW'(1);

    // Player p always attacks the secret of the following player, wrapping to 0
    always_comb begin
        target = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (next_player == PW'(p)) target = secret[p];
        end
    end

    // One digit pair is compared per CALC cycle; counts saturate rather than wrap
    always_comb begin
        g_digit   = guess[idx_i*DIGIT_W +: DIGIT_W];
        t_digit   = target[idx_j*DIGIT_W +: DIGIT_W];
        hit       = (g_digit == t_digit);
        last_pair = (idx_i == LAST_D) && (idx_j == LAST_D);
        bulls_n   = bulls;
        cows_n    = cows;
        if (hit && (idx_i == idx_j) && (bulls != '1)) bulls_n = bulls + CW'(1);
        if (hit && (idx_i != idx_j) && (cows != '1))  cows_n  = cows + CW'(1);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_SETUP;
        else       state <= state_n;
    end

    // Next-state logic; the enter edge is deliberately ignored while scoring
    always_comb begin
        state_n = state;
        case (state)
            S_SETUP:  if (ent && code_ok && (player == LAST_P)) state_n = S_GUESS;
            S_GUESS:  if (ent && code_ok) state_n = S_CALC;
            S_CALC:   if (last_pair) state_n = (bulls_n == ALL_BULLS) ? S_WIN : S_RESULT;
            S_RESULT: if (ent) begin
                if ((player == LAST_P) && (round_n == ROUND_LIMIT)) state_n = S_DRAW;
                else                                                state_n = S_GUESS;
            end
            S_WIN:    if (ent) state_n = S_SETUP;
            S_DRAW:   if (ent) state_n = S_SETUP;
            default:  state_n = S_SETUP;
        endcase
    end

    // Output decode from the current state and registered datapath
    always_comb begin
        state_o  = state;
        player_o = player;
        bulls_o  = bulls;
        cows_o   = cows;
        round_o  = round;
        reject_o = reject;
        busy_o   = (state == S_CALC);
        draw_o   = (state == S_DRAW);
        win_o    = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            win_o[p] = (state == S_WIN) && (player == PW'(p));
        end
    end

    // Datapath: secrets, guess, scoring counters, turn/round tracking, reject pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_q <= 1'b0;
            reject  <= 1'b0;
            player  <= '0;
            round   <= '0;
            bulls   <= '0;
            cows    <= '0;
            guess   <= '0;
            idx_i   <= '0;
            idx_j   <= '0;
            for (int p = 0; p < N_PLAYERS; p++) secret[p] <= '0;
        end else begin
            enter_q <= enter;
            reject  <= 1'b0;
            case (state)
                S_SETUP: if (ent) begin
                    if (code_ok) begin
                        for (int p = 0; p < N_PLAYERS; p++) begin
                            if (player == PW'(p)) secret[p] <= sw;
                        end
                        player <= next_player;
                    end else begin
                        reject <= 1'b1;
                    end
                end
                S_GUESS: if (ent) begin
                    if (code_ok) begin
                        guess <= sw;
                        bulls <= '0;
                        cows  <= '0;
                        idx_i <= '0;
                        idx_j <= '0;
                    end else begin
                        reject <= 1'b1;
                    end
                end
                S_CALC: begin
                    bulls <= bulls_n;
                    cows  <= cows_n;
                    if (last_pair) begin
                        idx_i <= '0;
                        idx_j <= '0;
                    end else if (idx_j == LAST_D) begin
                        idx_j <= '0;
                        idx_i <= idx_i + IW'(1);
                    end else begin
                        idx_j <= idx_j + IW'(1);
                    end
                end
                S_RESULT: if (ent) begin
                    player <= next_player;
                    if (player == LAST_P) round <= round_n;
                end
                S_WIN, S_DRAW: if (ent) begin
                    player <= '0;
                    round  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bulls_cows_arena.sv
// tb/tb_bulls_cows_arena.sv - directed self-checking bench for bulls_cows_arena
`timescale 1ns/1ps

module tb_bulls_cows_arena;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Default configuration
    logic        reset_a = 1'b1, enter_a = 1'b0, draw_a, reject_a, busy_a;
    logic [15:0] sw_a = '0;
    logic [2:0]  state_a, bulls_a, cows_a;
    logic [0:0]  player_a;
    logic [3:0]  round_a;
    logic [1:0]  win_a;

    // MAX_ROUNDS = 2
    logic        reset_r = 1'b1, enter_r = 1'b0, draw_r, reject_r, busy_r;
    logic [15:0] sw_r = '0;
    logic [2:0]  state_r, bulls_r, cows_r;
    logic [0:0]  player_r;
    logic [1:0]  round_r;
    logic [1:0]  win_r;

    // N_PLAYERS = 3, N_DIGITS = 5
    logic        reset_3 = 1'b1, enter_3 = 1'b0, draw_3, reject_3, busy_3;
    logic [19:0] sw_3 = '0;
    logic [2:0]  state_3, bulls_3, cows_3;
    logic [1:0]  player_3;
    logic [3:0]  round_3;
    logic [2:0]  win_3;

    bulls_cows_arena dut_a (
        .clock(clock), .reset(reset_a), .sw(sw_a), .enter(enter_a),
        .state_o(state_a), .player_o(player_a), .bulls_o(bulls_a), .cows_o(cows_a),
        .round_o(round_a), .win_o(win_a), .draw_o(draw_a), .reject_o(reject_a), .busy_o(busy_a)
    );

    bulls_cows_arena #(.MAX_ROUNDS(2)) dut_r (
        .clock(clock), .reset(reset_r), .sw(sw_r), .enter(enter_r),
        .state_o(state_r), .player_o(player_r), .bulls_o(bulls_r), .cows_o(cows_r),
        .round_o(round_r), .win_o(win_r), .draw_o(draw_r), .reject_o(reject_r), .busy_o(busy_r)
    );

    bulls_cows_arena #(.N_PLAYERS(3), .N_DIGITS(5)) dut_3 (
        .clock(clock), .reset(reset_3), .sw(sw_3), .enter(enter_3),
        .state_o(state_3), .player_o(player_3), .bulls_o(bulls_3), .cows_o(cows_3),
        .round_o(round_3), .win_o(win_3), .draw_o(draw_3), .reject_o(reject_3), .busy_o(busy_3)
    );

    // One enter press: low across an edge, high across exactly one edge, then low
    task automatic press(input int which, input logic [19:0] code);
        @(posedge clock); #1;
        case (which)
            0: begin sw_a = code[15:0]; enter_a = 1'b1; end
            1: begin sw_r = code[15:0]; enter_r = 1'b1; end
            default: begin sw_3 = code; enter_3 = 1'b1; end
        endcase
        @(posedge clock); #1;
        enter_a = 1'b0; enter_r = 1'b0; enter_3 = 1'b0;
    endtask

    // Counts negedges with busy high, bounded so a stuck DUT cannot hang the run
    task automatic count_busy(input int which, output int cyc);
        logic b;
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            b = (which == 0) ? busy_a : (which == 1) ? busy_r : busy_3;
            if (!b) break;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset_a = 1'b1;
        repeat (2) @(negedge clock);
        tests++; if (state_a !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state_a); end
        tests++; if (player_a !== 1'b0) begin fails++; $display("FAIL reset_player got=%0d exp=0", player_a); end
        tests++; if ({bulls_a, cows_a, round_a} !== 10'd0) begin fails++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0", bulls_a, cows_a, round_a); end
        tests++; if ({win_a, draw_a, reject_a, busy_a} !== 5'd0) begin fails++; $display("FAIL reset_flags got=%b exp=00000", {win_a, draw_a, reject_a, busy_a}); end
        reset_a = 1'b0;
    endtask

    task automatic test_reject;
        press(0, 20'h01123);
        @(negedge clock);
        tests++; if (reject_a !== 1'b1) begin fails++; $display("FAIL reject_repeat got=%b exp=1", reject_a); end
        tests++; if (player_a !== 1'b0) begin fails++; $display("FAIL reject_player got=%0d exp=0", player_a); end
        @(negedge clock);
        tests++; if (reject_a !== 1'b0) begin fails++; $display("FAIL reject_width got=%b exp=0", reject_a); end
        press(0, 20'h012A3);
        @(negedge clock);
        tests++; if (reject_a !== 1'b1) begin fails++; $display("FAIL reject_range got=%b exp=1", reject_a); end
        tests++; if (state_a !== 3'd0) begin fails++; $display("FAIL reject_state got=%0d exp=0", state_a); end
    endtask

    task automatic test_score;
        int cyc;
        press(0, 20'h01234);
        @(negedge clock);
        tests++; if (player_a !== 1'b1) begin fails++; $display("FAIL setup_p1 got=%0d exp=1", player_a); end
        press(0, 20'h05678);
        @(negedge clock);
        tests++; if (state_a !== 3'd1 || player_a !== 1'b0) begin fails++; $display("FAIL setup_done got=%0d/%0d exp=1/0", state_a, player_a); end
        press(0, 20'h05687);
        count_busy(0, cyc);
        tests++; if (cyc !== 16) begin fails++; $display("FAIL calc_cycles got=%0d exp=16", cyc); end
        tests++; if (state_a !== 3'd3) begin fails++; $display("FAIL score_state got=%0d exp=3", state_a); end
        tests++; if (bulls_a !== 3'd2 || cows_a !== 3'd2) begin fails++; $display("FAIL score_bc got=%0d/%0d exp=2/2", bulls_a, cows_a); end
    endtask

    task automatic test_win;
        int cyc;
        press(0, 20'h0);
        @(negedge clock);
        tests++; if (state_a !== 3'd1 || player_a !== 1'b1) begin fails++; $display("FAIL ack_p1 got=%0d/%0d exp=1/1", state_a, player_a); end
        press(0, 20'h01234);
        count_busy(0, cyc);
        tests++; if (cyc !== 16) begin fails++; $display("FAIL win_cycles got=%0d exp=16", cyc); end
        tests++; if (state_a !== 3'd4 || win_a !== 2'b10) begin fails++; $display("FAIL win_state got=%0d/%b exp=4/10", state_a, win_a); end
        tests++; if (bulls_a !== 3'd4 || cows_a !== 3'd0 || player_a !== 1'b1) begin fails++; $display("FAIL win_regs got=%0d/%0d/%0d exp=4/0/1", bulls_a, cows_a, player_a); end
        repeat (3) @(negedge clock);
        tests++; if (win_a !== 2'b10) begin fails++; $display("FAIL win_hold got=%b exp=10", win_a); end
        press(0, 20'h0);
        @(negedge clock);
        tests++; if (state_a !== 3'd0 || win_a !== 2'b00 || player_a !== 1'b0 || round_a !== 4'd0) begin fails++; $display("FAIL win_restart got=%0d/%b/%0d/%0d exp=0/00/0/0", state_a, win_a, player_a, round_a); end
    endtask

    task automatic test_draw;
        int cyc;
        reset_r = 1'b1;
        repeat (2) @(negedge clock);
        reset_r = 1'b0;
        press(1, 20'h01234);
        press(1, 20'h05678);
        for (int g = 0; g < 4; g++) begin
            press(1, (g % 2 == 0) ? 20'h04321 : 20'h08765);
            count_busy(1, cyc);
            tests++; if (state_r !== 3'd3) begin fails++; $display("FAIL draw_result%0d got=%0d exp=3", g, state_r); end
            press(1, 20'h0);
            @(negedge clock);
            if (g == 1) begin
                tests++; if (round_r !== 2'd1 || state_r !== 3'd1) begin fails++; $display("FAIL draw_round1 got=%0d/%0d exp=1/1", round_r, state_r); end
            end
        end
        tests++; if (round_r !== 2'd2) begin fails++; $display("FAIL draw_round got=%0d exp=2", round_r); end
        tests++; if (state_r !== 3'd5 || draw_r !== 1'b1) begin fails++; $display("FAIL draw_state got=%0d/%b exp=5/1", state_r, draw_r); end
        press(1, 20'h0);
        @(negedge clock);
        tests++; if (state_r !== 3'd0 || draw_r !== 1'b0 || round_r !== 2'd0) begin fails++; $display("FAIL draw_restart got=%0d/%b/%0d exp=0/0/0", state_r, draw_r, round_r); end
    endtask

    task automatic test_enter_hold;
        int cnt, entries;
        logic prev;
        press(0, 20'h01234);
        press(0, 20'h05678);
        @(posedge clock); #1;
        sw_a = 16'h4321; enter_a = 1'b1;
        cnt = 0; entries = 0; prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (busy_a) cnt++;
            if (busy_a && !prev) entries++;
            prev = busy_a;
        end
        enter_a = 1'b0;
        tests++; if (entries !== 1 || cnt !== 16) begin fails++; $display("FAIL hold_calc got=%0d/%0d exp=1/16", entries, cnt); end
        tests++; if (state_a !== 3'd3) begin fails++; $display("FAIL hold_state got=%0d exp=3", state_a); end
    endtask

    task automatic test_toggle_in_calc;
        int cnt;
        press(0, 20'h0);
        press(0, 20'h08765);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            enter_a = (k < 10) ? k[0] : 1'b0;
            @(negedge clock);
            if (busy_a) cnt++;
            if (k == 12) begin
                tests++; if (state_a !== 3'd2) begin fails++; $display("FAIL toggle_mid got=%0d exp=2", state_a); end
            end
            @(posedge clock); #1;
        end
        tests++; if (cnt !== 16 || state_a !== 3'd3) begin fails++; $display("FAIL toggle_calc got=%0d/%0d exp=16/3", cnt, state_a); end
    endtask

    task automatic test_reset_in_calc;
        press(0, 20'h0);
        @(negedge clock);
        tests++; if (round_a !== 4'd1 || player_a !== 1'b0) begin fails++; $display("FAIL round_inc got=%0d/%0d exp=1/0", round_a, player_a); end
        press(0, 20'h05687);
        repeat (6) @(posedge clock);
        #2;
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL pre_reset_busy got=%b exp=1", busy_a); end
        reset_a = 1'b1;
        #1;
        tests++; if (state_a !== 3'd0 || busy_a !== 1'b0 || player_a !== 1'b0) begin fails++; $display("FAIL async_reset got=%0d/%b/%0d exp=0/0/0", state_a, busy_a, player_a); end
        tests++; if ({bulls_a, cows_a, round_a, win_a, draw_a, reject_a} !== 14'd0) begin fails++; $display("FAIL async_reset_regs got=%h exp=0", {bulls_a, cows_a, round_a, win_a, draw_a, reject_a}); end
        @(negedge clock);
        reset_a = 1'b0;
    endtask

    task automatic test_three_players;
        int cyc;
        reset_3 = 1'b1;
        repeat (2) @(negedge clock);
        reset_3 = 1'b0;
        press(2, 20'h01234);
        press(2, 20'h56789);
        press(2, 20'h98765);
        @(negedge clock);
        tests++; if (state_3 !== 3'd1 || player_3 !== 2'd0) begin fails++; $display("FAIL p3_setup got=%0d/%0d exp=1/0", state_3, player_3); end
        press(2, 20'h01234);
        count_busy(2, cyc);
        tests++; if (cyc !== 25 || state_3 !== 3'd3 || bulls_3 !== 3'd0 || cows_3 !== 3'd0) begin fails++; $display("FAIL p3_guess0 got=%0d/%0d/%0d/%0d exp=25/3/0/0", cyc, state_3, bulls_3, cows_3); end
        press(2, 20'h0);
        press(2, 20'h98756);
        count_busy(2, cyc);
        tests++; if (state_3 !== 3'd3 || bulls_3 !== 3'd3 || cows_3 !== 3'd2) begin fails++; $display("FAIL p3_guess1 got=%0d/%0d/%0d exp=3/3/2", state_3, bulls_3, cows_3); end
        press(2, 20'h0);
        @(negedge clock);
        tests++; if (player_3 !== 2'd2) begin fails++; $display("FAIL p3_turn got=%0d exp=2", player_3); end
        press(2, 20'h01234);
        count_busy(2, cyc);
        tests++; if (state_3 !== 3'd4 || win_3 !== 3'b100 || bulls_3 !== 3'd5) begin fails++; $display("FAIL p3_win got=%0d/%b/%0d exp=4/100/5", state_3, win_3, bulls_3); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        test_reset();
        test_reject();
        test_score();
        test_win();
        test_draw();
        test_enter_hold();
        test_toggle_in_calc();
        test_reset_in_calc();
        test_three_players();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
